// File: rtl/store_narrow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_narrow_pkg
// Purpose  : Shared definitions for the store narrowing / lane-alignment
//            block: size encodings, byte-enable constants, FIFO entry type
//            and the store-value overflow check.
// Revision : 1.0  initial release
// ============================================================================
package store_narrow_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Entries always carry a full 32-bit address; narrower ADDR_W values use
  // the low bits.
  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_DATA_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
    logic [3:0]              byte_en;
    logic                    ovf;
  } entry_t;

  // True when the register value does not fit in the store width.
  // Signed: every bit from the sign position of the narrow type upward must
  // match. Unsigned: every bit above the narrow type must be zero.
  function automatic logic ovf_check(input logic [1:0]  size,
                                     input logic [31:0] data,
                                     input logic        is_signed);
    logic res;
    res = 1'b0;
    case (size)
      SZ_BYTE: res = is_signed ? !((&data[31:7]) || !(|data[31:7]))
                               : (|data[31:8]);
      SZ_HALF: res = is_signed ? !((&data[31:15]) || !(|data[31:15]))
                               : (|data[31:16]);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_narrow_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : narrow_lane_align
// Purpose  : Combinational narrowing of a register value onto the memory
//            byte lanes with byte-enable generation and alignment check.
// Ports    : i_size    - store size (byte/half/word/reserved)
//            i_addr_lo - byte offset within the word
//            i_data    - register value
//            o_data    - lane-aligned data, unused lanes zero
//            o_byte_en - byte enables, bit i covers bits [8i+7:8i]
//            o_legal   - request is naturally aligned and size is defined
// Revision : 1.0  initial release
// ============================================================================
module narrow_lane_align
  import store_narrow_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic [3:0]  o_byte_en,
  output logic        o_legal
);

  always_comb begin
    o_data    = '0;
    o_byte_en = BE_NONE;
    o_legal   = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_legal   = 1'b1;
        o_data    = {24'd0, i_data[7:0]} << {i_addr_lo, 3'b000};
        o_byte_en = BE_BYTE0 << i_addr_lo;
      end
      SZ_HALF: begin
        o_legal = !i_addr_lo[0];
        if (i_addr_lo[1]) begin
          o_data    = {i_data[15:0], 16'd0};
          o_byte_en = BE_HI_HALF;
        end else begin
          o_data    = {16'd0, i_data[15:0]};
          o_byte_en = BE_LO_HALF;
        end
      end
      SZ_WORD: begin
        o_legal   = (i_addr_lo == 2'b00);
        o_data    = i_data;
        o_byte_en = BE_WORD;
      end
      default: begin
        o_legal   = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_narrow.sv
`default_nettype none
// ============================================================================
// Module   : store_narrow
// Purpose  : Narrows a register value to byte/half/word, aligns it onto the
//            data-memory byte lanes, generates byte enables and queues the
//            result in a DEPTH-entry FIFO. Misaligned or reserved-size
//            requests are consumed and flagged with a one-cycle error pulse.
// Config   : STORE_NARROW_OVF_CHECK_EN - when defined, each entry records
//            whether the value fits the store width (outOvf); otherwise
//            outOvf is constant zero.
// Params   : DATA_W (32 only), ADDR_W (<=32), DEPTH (power of two, >=2)
// Ports    : clk, reset (sync, active-high)
//            inValid/inReady, inAddr, inData, inSize, inSigned - request
//            outValid/outReady, outAddr, outData, outByteEn, outOvf - head
//            misalignErr - one-cycle pulse after a rejected request
// Revision : 1.0  initial release
// ============================================================================
module store_narrow
  import store_narrow_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  output logic              inReady,
  input  logic [ADDR_W-1:0] inAddr,
  input  logic [DATA_W-1:0] inData,
  input  logic [1:0]        inSize,
  input  logic              inSigned,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W-1:0] outAddr,
  output logic [DATA_W-1:0] outData,
  output logic [3:0]        outByteEn,
  output logic              outOvf,
  output logic              misalignErr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;

  logic [31:0]        w_al_data;
  logic [3:0]         w_al_be;
  logic               w_legal;
  logic               w_ovf;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  entry_t             w_new;
  entry_t             w_head;

  narrow_lane_align u_align (
    .i_size    (inSize),
    .i_addr_lo (inAddr[1:0]),
    .i_data    (inData),
    .o_data    (w_al_data),
    .o_byte_en (w_al_be),
    .o_legal   (w_legal)
  );

`ifdef STORE_NARROW_OVF_CHECK_EN
  assign w_ovf = ovf_check(inSize, inData, inSigned);
`else
  // Signedness only matters to the overflow check.
  logic w_unused_signed;
  assign w_unused_signed = inSigned;
  assign w_ovf           = 1'b0;
`endif

  // inReady depends only on occupancy, so a full FIFO never accepts even if
  // the head is being popped in the same cycle.
  assign inReady  = (r_count < CNT_W'(DEPTH));
  assign outValid = (r_count != '0);

  // Illegal requests still complete the handshake; they just never enter
  // the FIFO.
  assign w_accept = inValid && inReady;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = outValid && outReady;

  always_comb begin
    w_new         = '0;
    w_new.addr    = ENTRY_ADDR_W'({inAddr[ADDR_W-1:2], 2'b00});
    w_new.data    = w_al_data;
    w_new.byte_en = w_al_be;
    w_new.ovf     = w_ovf;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields are forced to zero while the FIFO is empty so stale entries
  // never reach memory-side logic and reset leaves all outputs at zero.
  assign w_head      = r_mem[r_rd_ptr];
  assign outAddr     = outValid ? w_head.addr[ADDR_W-1:0] : '0;
  assign outData     = outValid ? DATA_W'(w_head.data)    : '0;
  assign outByteEn   = outValid ? w_head.byte_en          : BE_NONE;
  assign outOvf      = outValid && w_head.ovf;
  assign misalignErr = r_err;

endmodule
`default_nettype wire

// File: tb/tb_store_narrow.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_narrow
// Purpose  : Self-checking bench for store_narrow: directed scenarios plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_store_narrow;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [31:0] inAddr;
  logic [31:0] inData;
  logic [1:0]  inSize;
  logic        inSigned;
  logic        outValid;
  logic        outReady;
  logic [31:0] outAddr;
  logic [31:0] outData;
  logic [3:0]  outByteEn;
  logic        outOvf;
  logic        misalignErr;

  store_narrow #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .inValid     (inValid),
    .inReady     (inReady),
    .inAddr      (inAddr),
    .inData      (inData),
    .inSize      (inSize),
    .inSigned    (inSigned),
    .outValid    (outValid),
    .outReady    (outReady),
    .outAddr     (outAddr),
    .outData     (outData),
    .outByteEn   (outByteEn),
    .outOvf      (outOvf),
    .misalignErr (misalignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        ovf;
  } m_entry_t;

  m_entry_t q[$];
  logic     m_err;
  logic     m_rst;
  int       n_vec;
  int       n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_legal(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return a[0] == 1'b0;
      2'd2:    return a[1:0] == 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  // Range-based overflow reference: does the value fit the narrow type?
  function automatic logic m_ovf(input logic [1:0] sz, input logic [31:0] d, input logic sg);
`ifdef STORE_NARROW_OVF_CHECK_EN
    int s;
    s = $signed(d);
    if (sz == 2'd0) return sg ? (s < -128 || s > 127) : (d > 32'd255);
    if (sz == 2'd1) return sg ? (s < -32768 || s > 32767) : (d > 32'd65535);
    return 1'b0;
`else
    return 1'b0 & sz[0] & d[0] & sg;
`endif
  endfunction

  function automatic m_entry_t m_make(input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] d, input logic sg);
    m_entry_t e;
    int       off;
    off    = a[1:0];
    e.addr = a & 32'hFFFF_FFFC;
    e.ovf  = m_ovf(sz, d, sg);
    if (sz == 2'd0) begin
      e.data = (d & 32'hFF) * (32'd1 << (8 * off));
      e.be   = 4'(1 << off);
    end else if (sz == 2'd1) begin
      e.data = (off >= 2) ? ((d & 32'hFFFF) * 32'h10000) : (d & 32'hFFFF);
      e.be   = (off >= 2) ? 4'hC : 4'h3;
    end else begin
      e.data = d;
      e.be   = 4'hF;
    end
    return e;
  endfunction

  task automatic compare();
    chk("outValid", 32'(outValid), 32'(q.size() != 0));
    chk("inReady", 32'(inReady), 32'(q.size() < DEPTH));
    chk("misalignErr", 32'(misalignErr), 32'(m_err));
    if (q.size() != 0) begin
      chk("outAddr", outAddr, q[0].addr);
      chk("outData", outData, q[0].data);
      chk("outByteEn", 32'(outByteEn), 32'(q[0].be));
      chk("outOvf", 32'(outOvf), 32'(q[0].ovf));
    end else if (m_rst) begin
      chk("rst_outAddr", outAddr, 32'd0);
      chk("rst_outData", outData, 32'd0);
      chk("rst_outByteEn", 32'(outByteEn), 32'd0);
      chk("rst_outOvf", 32'(outOvf), 32'd0);
    end
  endtask

  // Drive one cycle of stimulus, advance the model across the same edge,
  // then check outputs half a cycle later.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic sg, input logic ordy,
                      input logic rst);
    logic acc;
    logic pop;
    reset    = rst;
    inValid  = v;
    inAddr   = a;
    inData   = d;
    inSize   = sz;
    inSigned = sg;
    outReady = ordy;
    if (rst) begin
      q.delete();
      m_err = 1'b0;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      acc   = v && (q.size() < DEPTH);
      pop   = (q.size() != 0) && ordy;
      m_err = acc && !m_legal(sz, a);
      if (pop) void'(q.pop_front());
      if (acc && m_legal(sz, a)) q.push_back(m_make(sz, a, d, sg));
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    m_err  = 1'b0;
    m_rst  = 1'b0;

    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Byte store on the top lane.
    step(1'b1, 32'h103, 32'h0000_00A5, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("t1_addr", outAddr, 32'h100);
    chk("t1_data", outData, 32'hA500_0000);
    chk("t1_be", 32'(outByteEn), 32'h8);
    idle(1'b1);

    // Upper half store, then a misaligned half.
    step(1'b1, 32'h202, 32'h0000_1234, 2'd1, 1'b0, 1'b1, 1'b0);
    chk("t2_data", outData, 32'h1234_0000);
    chk("t2_be", 32'(outByteEn), 32'hC);
    step(1'b1, 32'h201, 32'h0000_1234, 2'd1, 1'b0, 1'b1, 1'b0);
    chk("t2_err", 32'(misalignErr), 32'd1);
    chk("t2_novalid", 32'(outValid), 32'd0);
    idle(1'b1);
    chk("t2_err_once", 32'(misalignErr), 32'd0);

    // Back-pressure: three words with memory stalled, then drain.
    step(1'b1, 32'h300, 32'h1111_1111, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h304, 32'h2222_2222, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("t3_full", 32'(inReady), 32'd0);
    step(1'b1, 32'h308, 32'h3333_3333, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("t3_head_held", outData, 32'h1111_1111);
    step(1'b1, 32'h308, 32'h3333_3333, 2'd2, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h308, 32'h3333_3333, 2'd2, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Simultaneous push and pop at count 1.
    step(1'b1, 32'h400, 32'hAAAA_0001, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h404, 32'hAAAA_0002, 2'd2, 1'b0, 1'b1, 1'b0);
    chk("t4_head", outData, 32'hAAAA_0002);
    chk("t4_ready", 32'(inReady), 32'd1);
    idle(1'b1);

`ifdef STORE_NARROW_OVF_CHECK_EN
    step(1'b1, 32'h500, 32'hFFFF_FF80, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("t5_sbyte_neg", 32'(outOvf), 32'd0);
    step(1'b1, 32'h500, 32'h0000_0080, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("t5_sbyte_pos", 32'(outOvf), 32'd1);
    step(1'b1, 32'h500, 32'h0001_0000, 2'd1, 1'b0, 1'b1, 1'b0);
    chk("t5_uhalf", 32'(outOvf), 32'd1);
    idle(1'b1);
`endif

    // Reset with two entries queued.
    step(1'b1, 32'h600, 32'h5555_5555, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h604, 32'h6666_6666, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       d = $urandom_range(0, 255);
        1:       d = 32'hFFFF_FF00 | $urandom_range(0, 255);
        2:       d = $urandom_range(0, 131071);
        default: d = $urandom;
      endcase
      step(1'($urandom_range(0, 3) != 0), $urandom, d, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 59) == 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
